// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and constants for the BRAM burst reader
package bram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

  localparam int BUF_DEPTH = 4;

endpackage

// File: rtl/bram_burst_reader_if.sv
// rtl/bram_burst_reader_if.sv - control, RAM port-B and stream signals of the burst reader
interface bram_burst_reader_if #(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int LW = AW + 1;

  logic                 start;
  logic [AW-1:0]        start_address;
  logic [LW-1:0]        burst_length;
  logic                 busy;
  logic                 done;
  logic                 read_enable_B;
  logic [AW-1:0]        address_B;
  logic [RAM_WIDTH-1:0] data_out_B;
  logic [RAM_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    input  start, start_address, burst_length, data_out_B, m_ready,
    output busy, done, read_enable_B, address_B, m_data, m_valid
  );

  modport slave (
    output start, start_address, burst_length, data_out_B, m_ready,
    input  busy, done, read_enable_B, address_B, m_data, m_valid
  );

endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small synchronous FIFO holding RAM words awaiting the stream consumer
module stream_fifo
  import bram_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_empty,
  output logic                         o_full,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage is cleared on reset so the head reads as zero when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

endmodule

// File: rtl/bram_burst_reader.sv
// rtl/bram_burst_reader.sv - streams bursts of consecutive words from RAM port B with credit-based flow control
module bram_burst_reader
  import bram_pkg::*;
#(
  parameter int RAM_WIDTH = 16,
  parameter int RAM_DEPTH = 1024
) (
  input logic                 clk,
  input logic                 rst,
  bram_burst_reader_if.master bus
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_DEPTH - 1);

  rd_state_t            r_state, w_state_next;
  logic [AW-1:0]        r_addr, w_addr_next;
  logic [LW-1:0]        r_remaining, w_remaining_next;
  logic [CW-1:0]        r_credits, w_credits_next;
  logic                 r_ren, w_ren_next;
  logic                 r_done, w_done_next;
  logic                 r_inflight;
  logic                 w_issue;
  logic                 w_xfer;
  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic [CW-1:0]        w_fifo_count;
  logic [RAM_WIDTH-1:0] w_fifo_data;

  assign w_xfer = !w_fifo_empty && bus.m_ready;

  // Credits cover reads in flight plus buffered words, so the FIFO can never overflow.
  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_ren_next       = 1'b0;
    w_done_next      = 1'b0;
    w_issue          = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.burst_length == '0) begin
            w_done_next = 1'b1;
          end else begin
            w_issue          = 1'b1;
            w_ren_next       = 1'b1;
            w_addr_next      = bus.start_address;
            w_remaining_next = bus.burst_length - LW'(1);
            w_state_next     = (bus.burst_length == LW'(1)) ? DRAIN : READ;
          end
        end
      end
      READ: begin
        if (r_credits < CW'(BUF_DEPTH)) begin
          w_issue          = 1'b1;
          w_ren_next       = 1'b1;
          w_addr_next      = (r_addr == LAST_ADDR) ? '0 : r_addr + AW'(1);
          w_remaining_next = r_remaining - LW'(1);
          if (r_remaining == LW'(1)) w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fifo_count == CW'(1) && !r_inflight && !r_ren && w_xfer) begin
          w_done_next  = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase

    case ({w_issue, w_xfer})
      2'b10:   w_credits_next = r_credits + CW'(1);
      2'b01:   w_credits_next = r_credits - CW'(1);
      default: w_credits_next = r_credits;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_credits   <= '0;
      r_ren       <= 1'b0;
      r_done      <= 1'b0;
      r_inflight  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_credits   <= w_credits_next;
      r_ren       <= w_ren_next;
      r_done      <= w_done_next;
      r_inflight  <= r_ren;
    end
  end

  stream_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (r_inflight && !w_fifo_full),
    .i_pop   (w_xfer),
    .i_data  (bus.data_out_B),
    .o_data  (w_fifo_data),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = r_done;
  assign bus.read_enable_B = r_ren;
  assign bus.address_B     = r_addr;
  assign bus.m_valid       = !w_fifo_empty;
  assign bus.m_data        = w_fifo_data;

endmodule

// File: tb/tb_bram_burst_reader.sv
// tb/tb_bram_burst_reader.sv - directed self-checking bench for bram_burst_reader
module tb_bram_burst_reader;
  logic clk;
  logic rst;

  bram_burst_reader_if bus_if ();

  bram_burst_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: port-B read with one cycle of latency
  logic [15:0] ram [0:1023];
  always @(posedge clk) begin
    if (bus_if.read_enable_B) bus_if.data_out_B <= ram[bus_if.address_B];
  end

  int n_tests = 0;
  int n_fail  = 0;

  int got[$];
  int addrs[$];
  int first_v, done_c, issued, xfers, max_out, stall_bad, ren_at9;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".busy"}, 32'(bus_if.busy), 32'd0);
    check({tag, ".done"}, 32'(bus_if.done), 32'd0);
    check({tag, ".ren"}, 32'(bus_if.read_enable_B), 32'd0);
    check({tag, ".addr"}, 32'(bus_if.address_B), 32'd0);
    check({tag, ".m_valid"}, 32'(bus_if.m_valid), 32'd0);
    check({tag, ".m_data"}, 32'(bus_if.m_data), 32'd0);
  endtask

  // mode 0: ready held high; mode 1: ready low 10 cycles, then toggling
  task automatic burst(input int addr, input int len, input int mode,
                       input int inject_c, input int stop_after);
    logic        prev_stall;
    logic [15:0] prev_data;
    int          out;
    got.delete();
    addrs.delete();
    first_v = -1; done_c = -1; issued = 0; xfers = 0;
    max_out = 0; stall_bad = 0; ren_at9 = -1;
    prev_stall = 1'b0;
    prev_data  = '0;
    bus_if.start         = 1'b1;
    bus_if.start_address = addr[9:0];
    bus_if.burst_length  = len[10:0];
    tick();
    bus_if.start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (stop_after > 0 && xfers >= stop_after) return;
      if (prev_stall && bus_if.m_data !== prev_data) stall_bad++;
      if (bus_if.read_enable_B) begin
        issued++;
        addrs.push_back(int'(bus_if.address_B));
      end
      out = issued - xfers;
      if (out > max_out) max_out = out;
      if (c == 9) ren_at9 = int'(bus_if.read_enable_B);
      if (first_v < 0 && bus_if.m_valid) first_v = c;
      if (bus_if.done) begin
        done_c = c;
        return;
      end
      bus_if.start         = (c == inject_c);
      bus_if.start_address = 10'd500;
      bus_if.burst_length  = 11'd2;
      bus_if.m_ready       = (mode == 0) ? 1'b1 : ((c < 10) ? 1'b0 : c[0]);
      if (bus_if.m_valid && bus_if.m_ready) begin
        got.push_back(int'(bus_if.m_data));
        xfers++;
      end
      prev_stall = bus_if.m_valid && !bus_if.m_ready;
      prev_data  = bus_if.m_data;
      tick();
    end
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 8; i++) ram[i] = 16'hA000 + 16'(i);
    ram[1022] = 16'hBEEE;
    ram[1023] = 16'hBEEF;
    for (int i = 0; i < 16; i++) ram[100 + i] = 16'hD000 + 16'(i);
    for (int i = 0; i < 4; i++) ram[200 + i] = 16'hE000 + 16'(i);

    rst = 1'b1;
    bus_if.start = 1'b0;
    bus_if.start_address = '0;
    bus_if.burst_length = '0;
    bus_if.m_ready = 1'b0;
    repeat (3) tick();
    check_zero_outputs("reset");
    rst = 1'b0;
    tick();

    // Preload and stream
    burst(0, 8, 0, -1, 0);
    check("stream.first_valid", first_v, 2);
    check("stream.done_cycle", done_c, 10);
    check("stream.busy_at_done", 32'(bus_if.busy), 32'd0);
    check("stream.count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("stream.data%0d", i), got[i], 32'hA000 + i);
    tick();
    check("stream.done_pulse", 32'(bus_if.done), 32'd0);

    // Wrap-around
    burst(1022, 4, 0, -1, 0);
    check("wrap.addr_count", addrs.size(), 4);
    check("wrap.addr0", addrs[0], 1022);
    check("wrap.addr1", addrs[1], 1023);
    check("wrap.addr2", addrs[2], 0);
    check("wrap.addr3", addrs[3], 1);
    check("wrap.data0", got[0], 32'hBEEE);
    check("wrap.data1", got[1], 32'hBEEF);
    check("wrap.data2", got[2], 32'hA000);
    check("wrap.data3", got[3], 32'hA001);
    check("wrap.done_cycle", done_c, 6);
    tick();

    // Zero length
    burst(5, 0, 0, -1, 0);
    check("zero.done_cycle", done_c, 0);
    check("zero.reads", issued, 0);
    check("zero.words", got.size(), 0);
    tick();
    check("zero.done_pulse", 32'(bus_if.done), 32'd0);

    // Start asserted mid-burst is ignored
    burst(200, 4, 0, 1, 0);
    check("ignore.addr_count", addrs.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ignore.addr%0d", i), addrs[i], 200 + i);
    for (int i = 0; i < 4; i++) check($sformatf("ignore.data%0d", i), got[i], 32'hE000 + i);
    check("ignore.done_cycle", done_c, 6);
    tick();

    // Back-pressure
    burst(100, 16, 1, -1, 0);
    check("bp.words", got.size(), 16);
    for (int i = 0; i < 16; i++) check($sformatf("bp.data%0d", i), got[i], 32'hD000 + i);
    check("bp.max_outstanding", max_out, 4);
    check("bp.ren_when_full", ren_at9, 0);
    check("bp.stall_stable", stall_bad, 0);
    check("bp.reads", issued, 16);
    check("bp.done_seen", 32'(done_c >= 0), 32'd1);
    tick();

    // Reset mid-burst after three transfers
    burst(0, 8, 0, -1, 3);
    check("rstmid.xfers", xfers, 3);
    rst = 1'b1;
    bus_if.m_ready = 1'b0;
    tick();
    check_zero_outputs("rstmid");
    rst = 1'b0;
    bus_if.m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_if.m_valid || bus_if.read_enable_B || bus_if.busy) seen++;
    end
    check("rstmid.quiet", seen, 0);

    burst(4, 4, 0, -1, 0);
    check("fresh.words", got.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("fresh.data%0d", i), got[i], 32'hA004 + i);
    check("fresh.done_cycle", done_c, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
